shift_seq_ctrl: RTL

Multi-cycle shift unit controller for the execute stage.
- Sequences a narrow shift datapath, at most STEP bit positions per cycle, to perform 32-bit SLL/SRL/SRA/ROTR by a 0..31 amount.
- Uses a start/busy/done handshake so the pipeline can stall on long shifts.
- Replaces the single-cycle full barrel shift where area or timing is tight.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_seq_ctrl_if.sv | 18 +
 rtl/shift_step.sv | 24 ++
 rtl/shift_seq_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and encodings for the multi-cycle shift controller.
package shift_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SAW   = 5;
  localparam int unsigned STEP  = 4;
  localparam int unsigned AMTW  = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the shift controller.
interface shift_seq_ctrl_if
  import shift_pkg::*;
();

  logic             start;
  op_e              op;
  logic [SAW-1:0]   sa;
  logic [WIDTH-1:0] src;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;

  modport master (output start, op, sa, src, flush, input busy, done, res);
  modport slave  (input start, op, sa, src, flush, output busy, done, res);

endinterface

// File: rtl/shift_step.sv
// One partial shift of at most STEP positions; combinational.
module shift_step
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] work,
  input  op_e              op,
  input  logic [AMTW-1:0]  amt,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);

  // Arithmetic and rotate shifts go through a double-width word so the fill comes from the upper half.
  always_comb begin
    shifted = work;
    unique case (op)
      OP_SLL:  shifted = work << amt;
      OP_SRL:  shifted = work >> amt;
      OP_SRA:  shifted = WIDTH'({{WIDTH{sign}}, work} >> amt);
      OP_ROTR: shifted = WIDTH'({work, work} >> amt);
      default: shifted = work;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences shift_step over several cycles to perform a full 32-bit shift/rotate.
module shift_seq_ctrl
  import shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SAW-1:0]   rem_q, rem_d;
  op_e              op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AMTW-1:0]  amt;
  logic [WIDTH-1:0] step_out;

  shift_step u_step (
    .work    (work_q),
    .op      (op_q),
    .amt     (amt),
    .sign    (sign_q),
    .shifted (step_out)
  );

  // Step size is zero outside RUN so the datapath idles.
  always_comb begin
    amt = '0;
    if (state_q == ST_RUN) begin
      if (32'(rem_q) < STEP) amt = AMTW'(rem_q);
      else                   amt = AMTW'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update; flush overrides everything and leaves res untouched.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    res_d   = res_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_d   = bus.op;
            work_d = bus.src;
            rem_d  = bus.sa;
            sign_d = bus.src[WIDTH-1];
            if (bus.sa == '0) begin
              res_d   = bus.src;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          work_d = step_out;
          rem_d  = rem_q - SAW'(amt);
          if (rem_d == '0) begin
            res_d   = step_out;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.res  = res_q;

endmodule
